dout_writer: RTL and testbench
==============================

# dout_writer

Transmitter for the 4-lane ADC data-out interface that the board's ADC reader front end consumes. It serialises one frame of eight 24-bit channel samples onto drdy/dclk/dout[3:0] and acts as the source end of that link. It drives the ADC pmod pins in loop-back bench setups and feeds test patterns to the reader when no ADC is fitted.

## Interface
- DCLK_DIV, 4: clk cycles per dclk period; even, at least 2.
- GAP_CYCLES, 8: minimum clk cycles with dclk low between the end of one frame and the start of the next.
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous, active-low reset.
- tick_i  in  1  single-cycle request to send one frame.
- ch1_i … ch8_i  in  signed 24 each  channel samples, captured on the accepted tick_i.
- drdy_o  out  1  frame-start strobe.
- dclk_o  out  1  serial bit clock.
- dout_o  out  4  serial data lanes.
- busy_o  out  1  high from tick acceptance until the gap expires.
- done_o  out  1  one-cycle pulse at the end of the frame.
- overrun_o  out  1  one-cycle pulse when tick_i is dropped.

## Operation
- Lane mapping: lane k (k = 0..3) carries ch(2k+1), then ch(2k+2).
- Word format: 32 bits, sent MSB first.
  - Bits [31:24] are the header {ch_idx[2:0], 1'b0, frame_cnt[3:0]}.
    - ch_idx is the zero-based channel number.
    - frame_cnt is 4 bits, wraps 15→0, and increments on every done_o.
  - Bits [23:0] are the sample.
- Frame length: 64 bits per lane; all lanes are shifted in parallel.
- FSM states:
  - IDLE: on tick_i, latch all inputs and go to SHIFT.
  - SHIFT: 64 dclk periods, then go to GAP.
  - GAP: GAP_CYCLES clk cycles, then go to IDLE.
- tick_i is accepted only in IDLE. A tick_i in SHIFT or GAP is dropped and pulses overrun_o; the latched data is unchanged.
- A tick_i in the same cycle as GAP→IDLE is dropped (overrun_o pulses).
- Reset, asynchronous, including mid-frame:
  - state returns to IDLE;
  - all outputs go to 0;
  - frame_cnt goes to 0;
  - the shift registers clear.

## Timing
- Cycle T: tick_i accepted.
- T+1:
  - state is SHIFT;
  - busy_o = 1;
  - drdy_o = 1;
  - dclk_o = 0;
  - dout_o presents bit 63 of each lane.
- dclk_o rises DCLK_DIV/2 cycles after each bit is presented, and falls DCLK_DIV/2 cycles later.
- On each falling edge the next bit is presented in the same clk cycle. The reader samples on the rising edge, so data has DCLK_DIV/2 cycles of setup and hold.
- drdy_o deasserts on the first falling edge, so it is high for exactly DCLK_DIV cycles.
- The last falling edge of dclk_o comes at T+1+64·DCLK_DIV. In that cycle:
  - done_o = 1;
  - state becomes GAP;
  - dout_o goes to 0.
- busy_o falls after GAP_CYCLES in GAP.
- Minimum tick-to-tick spacing: 1 + 64·DCLK_DIV + GAP_CYCLES cycles.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Structure
- Package dout_pkg holds:
  - LANES=4, WORD_BITS=32, HEADER_BITS=8, FRAME_BITS=64;
  - typedef enum {IDLE, SHIFT, GAP} dout_state_t;
  - the header packing function.
- Sub-module dout_lane_shifter: a 64-bit parallel-load, MSB-first shift register. It is instantiated LANES times and shares the load and shift enables.
- The top level holds:
  - the FSM;
  - the dclk divider counter, of width $clog2(DCLK_DIV);
  - the 6-bit bit counter;
  - the gap counter;
  - frame_cnt.

## Test plan
All scenarios use DCLK_DIV=4 and GAP_CYCLES=8.
- Single frame, ch1..ch8 = 0x000001..0x000008:
  - lane 0 shifts 0x00000001 then 0x20000002;
  - lane 3 shifts 0xC0000007 then 0xE0000008;
  - done_o pulses at T+257.
- Loop-back into the ADC reader, ch1 = -1 (0xFFFFFF), ch8 = 0x7FFFFF: the reader reports ch1_o = -1, ch8_o = 8388607, and one reader tick_o per frame.
- Back-to-back ticks at spacing 260, then 266:
  - the first spacing pulses overrun_o and sends one frame;
  - the second spacing sends two frames, with frame_cnt 0 then 1.
- 17 frames: the header frame_cnt field goes 0..15, then 0.
- reset_ni is pulled low at bit 30 of a frame:
  - all outputs are 0 within the same cycle;
  - after release, tick_i gives a clean frame with frame_cnt=0.
- drdy/dclk check:
  - drdy_o is high for exactly 4 cycles;
  - there are 64 dclk_o rising edges per frame;
  - dout_o is stable for 2 cycles either side of every rising edge.

Source files
------------

// File: rtl/dout_pkg.sv
// Shared types and word-packing helpers for the 4-lane ADC data-out transmitter.
// The header layout is defined only here so that the writer and any reader model stay in step.
package dout_pkg;

    localparam int LANES       = 4;
    localparam int WORD_BITS   = 32;
    localparam int HEADER_BITS = 8;
    localparam int FRAME_BITS  = 64;
    localparam int SAMPLE_BITS = WORD_BITS - HEADER_BITS;
    localparam int CHANNELS    = 2 * LANES;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } dout_state_t;

    // Header is {channel index, reserved zero, 4-bit frame counter}.
    function automatic logic [HEADER_BITS-1:0] pack_header(
        input logic [2:0] ch_idx,
        input logic [3:0] frame_cnt
    );
        return {ch_idx, 1'b0, frame_cnt};
    endfunction

    function automatic logic [WORD_BITS-1:0] pack_word(
        input logic [2:0]             ch_idx,
        input logic [3:0]             frame_cnt,
        input logic [SAMPLE_BITS-1:0] sample
    );
        return {pack_header(ch_idx, frame_cnt), sample};
    endfunction

endpackage

// File: rtl/dout_lane_shifter.sv
// One serial lane: parallel-load, MSB-first shift register.
// Zeros shift in from the bottom, so a fully shifted frame leaves the lane idle low.
module dout_lane_shifter
    import dout_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/dout_writer.sv
// Source end of the 4-lane ADC data-out link: serialises eight 24-bit samples per frame
// onto drdy/dclk/dout with an enforced idle gap between frames.
module dout_writer
    import dout_pkg::*;
#(
    parameter int DCLK_DIV   = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               tick_i,
    input  logic signed [23:0] ch1_i,
    input  logic signed [23:0] ch2_i,
    input  logic signed [23:0] ch3_i,
    input  logic signed [23:0] ch4_i,
    input  logic signed [23:0] ch5_i,
    input  logic signed [23:0] ch6_i,
    input  logic signed [23:0] ch7_i,
    input  logic signed [23:0] ch8_i,
    output logic               drdy_o,
    output logic               dclk_o,
    output logic [3:0]         dout_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               overrun_o
);

    localparam int DIV_W = $clog2(DCLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(DCLK_DIV / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);

    dout_state_t            state;
    logic [DIV_W-1:0]       div_cnt;
    logic [5:0]             bit_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [3:0]             frame_cnt;
    logic                   load;
    logic                   shift;
    logic [SAMPLE_BITS-1:0] samples   [CHANNELS];
    logic [FRAME_BITS-1:0]  lane_data [LANES];

    assign samples[0] = ch1_i;
    assign samples[1] = ch2_i;
    assign samples[2] = ch3_i;
    assign samples[3] = ch4_i;
    assign samples[4] = ch5_i;
    assign samples[5] = ch6_i;
    assign samples[6] = ch7_i;
    assign samples[7] = ch8_i;

    assign load  = (state == IDLE) && tick_i;
    assign shift = (state == SHIFT) && (div_cnt == DIV_LAST);

    // Each lane carries an odd channel followed by the next even one, headers stamped at load.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_data[k] = {pack_word(3'(2 * k),     frame_cnt, samples[2 * k]),
                               pack_word(3'(2 * k + 1), frame_cnt, samples[2 * k + 1])};

        dout_lane_shifter #(
            .WIDTH (FRAME_BITS)
        ) u_shifter (
            .clk   (clk_i),
            .rst_n (reset_ni),
            .load  (load),
            .shift (shift),
            .data  (lane_data[k]),
            .msb   (dout_o[k])
        );
    end

    // The bit falls out of the shifter on the same edge that drops dclk, so data
    // is centred on the rising edge with half a dclk period either side.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            drdy_o    <= 1'b0;
            dclk_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            overrun_o <= tick_i && (state != IDLE);
            case (state)
                IDLE: begin
                    if (tick_i) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        busy_o  <= 1'b1;
                        drdy_o  <= 1'b1;
                        dclk_o  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        dclk_o  <= 1'b0;
                        drdy_o  <= 1'b0;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state     <= GAP;
                            gap_cnt   <= '0;
                            done_o    <= 1'b1;
                            frame_cnt <= frame_cnt + 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                        if (div_cnt == DIV_RISE) begin
                            dclk_o <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dout_writer.sv
// Self-checking bench for dout_writer: a timeline model of the link predicts every output
// each cycle, and a small serial reader reassembles frames for literal end-to-end checks.
module tb_dout_writer;

    localparam int DIV       = 4;
    localparam int GAP       = 8;
    localparam int SHIFT_LEN = 64 * DIV;
    localparam int BUSY_LEN  = SHIFT_LEN + GAP;

    logic               clk      = 1'b0;
    logic               reset_ni = 1'b0;
    logic               tick_i   = 1'b0;
    logic signed [23:0] ch [8];
    logic               drdy_o;
    logic               dclk_o;
    logic [3:0]         dout_o;
    logic               busy_o;
    logic               done_o;
    logic               overrun_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: when the current frame started and what each lane must carry.
    int          cyc        = 0;
    bit          active     = 1'b0;
    int          start      = 0;
    int          accepted_n = 0;
    bit          exp_ovr    = 1'b0;
    logic [63:0] exp_lane [4];

    // Serial reader state.
    logic [63:0] rx_lane [4];
    logic [63:0] rx_last [4];
    int          rx_bits      = 0;
    int          rx_frames    = 0;
    int          rise_count   = 0;
    int          rise_at_done = 0;
    int          drdy_run     = 0;
    int          drdy_len     = 0;
    int          done_cycle   = 0;
    int          ovr_count    = 0;
    int          stab_err     = 0;
    logic [3:0]  hist1        = 4'd0;
    logic [3:0]  hist2        = 4'd0;
    logic [3:0]  rise_val     = 4'd0;
    bit          hold_pending = 1'b0;
    bit          prev_dclk    = 1'b0;
    bit          prev_drdy    = 1'b0;
    logic [3:0]  hdr_q [$];

    dout_writer #(
        .DCLK_DIV   (DIV),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .tick_i    (tick_i),
        .ch1_i     (ch[0]),
        .ch2_i     (ch[1]),
        .ch3_i     (ch[2]),
        .ch4_i     (ch[3]),
        .ch5_i     (ch[4]),
        .ch6_i     (ch[5]),
        .ch7_i     (ch[6]),
        .ch8_i     (ch[7]),
        .drdy_o    (drdy_o),
        .dclk_o    (dclk_o),
        .dout_o    (dout_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [8:0] dut_outputs();
        return {drdy_o, dclk_o, dout_o, busy_o, done_o, overrun_o};
    endfunction

    // Lane k sends ch(2k+1) then ch(2k+2), each word = {idx, 0, frame_cnt, sample}.
    function automatic logic [63:0] model_lane(input int k, input logic [3:0] fc);
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = {3'(2 * k),     1'b0, fc, ch[2 * k]};
        w1 = {3'(2 * k + 1), 1'b0, fc, ch[2 * k + 1]};
        return {w0, w1};
    endfunction

    function automatic logic [8:0] expected_outputs();
        int         c;
        logic       e_drdy;
        logic       e_dclk;
        logic       e_busy;
        logic       e_done;
        logic [3:0] d;
        e_drdy = 1'b0;
        e_dclk = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        d      = 4'd0;
        c      = cyc - start;
        if (active && c < BUSY_LEN) begin
            e_busy = 1'b1;
            e_drdy = (c < DIV);
            e_done = (c == SHIFT_LEN);
            if (c < SHIFT_LEN) begin
                e_dclk = ((c % DIV) >= DIV / 2);
                for (int k = 0; k < 4; k++) begin
                    d[k] = exp_lane[k][63 - c / DIV];
                end
            end
        end
        return {e_drdy, e_dclk, d, e_busy, e_done, exp_ovr};
    endfunction

    task automatic receive();
        if (!reset_ni) begin
            rx_bits      = 0;
            hold_pending = 1'b0;
            drdy_run     = 0;
        end
        if (overrun_o) ovr_count++;
        if (done_o) begin
            done_cycle   = cyc;
            rise_at_done = rise_count;
        end
        if (drdy_o) begin
            if (!prev_drdy) begin
                rx_bits    = 0;
                rise_count = 0;
                drdy_run   = 0;
            end
            drdy_run++;
        end else if (prev_drdy) begin
            drdy_len = drdy_run;
        end
        if (hold_pending) begin
            if (dout_o !== rise_val) stab_err++;
            hold_pending = 1'b0;
        end
        if (dclk_o && !prev_dclk) begin
            if (!(dout_o === hist1 && hist1 === hist2)) stab_err++;
            hold_pending = 1'b1;
            rise_val     = dout_o;
            rise_count++;
            for (int k = 0; k < 4; k++) begin
                rx_lane[k] = {rx_lane[k][62:0], dout_o[k]};
            end
            rx_bits++;
            if (rx_bits == 64) begin
                for (int k = 0; k < 4; k++) rx_last[k] = rx_lane[k];
                rx_frames++;
                hdr_q.push_back(rx_lane[0][59:56]);
            end
        end
        hist2     = hist1;
        hist1     = dout_o;
        prev_dclk = dclk_o;
        prev_drdy = drdy_o;
    endtask

    // Model advances on each edge, then all outputs are compared 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_ni) begin
                active     = 1'b0;
                accepted_n = 0;
                exp_ovr    = 1'b0;
            end else begin
                exp_ovr = 1'b0;
                if (tick_i) begin
                    if (!active || (cyc - 1 - start) >= BUSY_LEN) begin
                        active = 1'b1;
                        start  = cyc;
                        for (int k = 0; k < 4; k++) begin
                            exp_lane[k] = model_lane(k, 4'(accepted_n % 16));
                        end
                        accepted_n++;
                    end else begin
                        exp_ovr = 1'b1;
                    end
                end
            end
            #1;
            checkOutput("outputs", 64'(dut_outputs()), 64'(expected_outputs()));
            receive();
        end
    end

    task automatic applyStimulus(input int target);
        do @(negedge clk); while (cyc < target);
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;
    endtask

    task automatic randomize_channels();
        for (int i = 0; i < 8; i++) ch[i] = 24'($urandom);
    endtask

    initial begin
        int                 t0;
        int                 t;
        int                 n;
        int                 o;
        logic signed [23:0] s;

        for (int i = 0; i < 8; i++) ch[i] = 24'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 64'(dut_outputs()), 64'd0);
        reset_ni = 1'b1;

        // Single frame with ch1..ch8 = 1..8.
        for (int i = 0; i < 8; i++) ch[i] = 24'(i + 1);
        t0 = cyc + 2;
        applyStimulus(t0);
        wait_until(t0 + 270);
        checkOutput("lane0_words", rx_last[0], 64'h00000001_20000002);
        checkOutput("lane3_words", rx_last[3], 64'hC0000007_E0000008);
        checkOutput("model_lane0", exp_lane[0], 64'h00000001_20000002);
        checkOutput("done_offset", 64'(done_cycle - t0), 64'd257);
        checkOutput("drdy_width", 64'(drdy_len), 64'd4);
        checkOutput("dclk_rises", 64'(rise_at_done), 64'd64);
        checkOutput("frames_single", 64'(rx_frames), 64'd1);

        // Loop-back extremes through the reader.
        randomize_channels();
        ch[0] = 24'hFFFFFF;
        ch[7] = 24'h7FFFFF;
        n  = rx_frames;
        t0 = cyc + 2;
        applyStimulus(t0);
        wait_until(t0 + 270);
        checkOutput("reader_frames", 64'(rx_frames - n), 64'd1);
        s = rx_last[0][55:32];
        checkOutput("reader_ch1", 64'(longint'(s)), 64'hFFFF_FFFF_FFFF_FFFF);
        s = rx_last[3][23:0];
        checkOutput("reader_ch8", 64'(longint'(s)), 64'd8388607);

        // Spacing 260: second tick lands in the gap window and is dropped.
        do_reset();
        hdr_q.delete();
        n  = rx_frames;
        o  = ovr_count;
        t0 = cyc + 2;
        applyStimulus(t0);
        applyStimulus(t0 + 260);
        wait_until(t0 + 300);
        checkOutput("spacing260_overruns", 64'(ovr_count - o), 64'd1);
        checkOutput("spacing260_frames", 64'(rx_frames - n), 64'd1);

        // Spacing 266: both ticks accepted.
        do_reset();
        hdr_q.delete();
        n  = rx_frames;
        o  = ovr_count;
        t0 = cyc + 2;
        applyStimulus(t0);
        applyStimulus(t0 + 266);
        wait_until(t0 + 266 + 270);
        checkOutput("spacing266_overruns", 64'(ovr_count - o), 64'd0);
        checkOutput("spacing266_frames", 64'(rx_frames - n), 64'd2);
        if (hdr_q.size() >= 2) begin
            checkOutput("spacing266_fcnt0", 64'(hdr_q[0]), 64'd0);
            checkOutput("spacing266_fcnt1", 64'(hdr_q[1]), 64'd1);
        end

        // 17 random frames, some with a dropped tick and fresh inputs mid-frame.
        do_reset();
        hdr_q.delete();
        n = rx_frames;
        t = cyc + 2;
        for (int i = 0; i < 17; i++) begin
            randomize_channels();
            applyStimulus(t);
            if ($urandom_range(0, 1) == 1) begin
                randomize_channels();
                applyStimulus(t + int'($urandom_range(2, 263)));
            end
            t = t + 265 + int'($urandom_range(0, 12));
        end
        wait_until(t + 5);
        checkOutput("frames_17", 64'(rx_frames - n), 64'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < hdr_q.size()) begin
                checkOutput($sformatf("fcnt_%0d", i), 64'(hdr_q[i]), 64'(i % 16));
            end
        end

        // Asynchronous reset in the middle of bit 30.
        do_reset();
        hdr_q.delete();
        randomize_channels();
        t0 = cyc + 2;
        applyStimulus(t0);
        wait_until(t0 + 134);
        checkOutput("busy_before_reset", 64'(busy_o), 64'd1);
        reset_ni = 1'b0;
        #1;
        checkOutput("reset_midframe", 64'(dut_outputs()), 64'd0);
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;
        hdr_q.delete();
        n = rx_frames;
        randomize_channels();
        t0 = cyc + 2;
        applyStimulus(t0);
        wait_until(t0 + 270);
        checkOutput("post_reset_frames", 64'(rx_frames - n), 64'd1);
        if (hdr_q.size() >= 1) begin
            checkOutput("post_reset_fcnt", 64'(hdr_q[0]), 64'd0);
        end
        checkOutput("dout_stability", 64'(stab_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
